// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start-bit detect, mid-bit sampling, LSB-first data,
// optional parity check and stop-bit validation with one-cycle result pulses.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  // Parity bit the transmitter is expected to append for this word.
  function automatic logic expected_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  // New bits enter at the MSB so the first received bit ends up at bit 0.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d,
                                                 input logic b);
    logic [DATA_W-1:0] r;
    r = d >> 1;
    r[DATA_W-1] = b;
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              par_bad_r, par_bad_s;
  logic [DATA_W-1:0] data_s;
  logic              valid_s, perr_s, ferr_s;

  // Next-state and datapath decode; counters restart at every sample point.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    par_bad_s = par_bad_r;
    data_s    = data_out;
    valid_s   = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!serial_in) begin
          state_s   = START;
          cnt_s     = '0;
          bit_cnt_s = '0;
          par_bad_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          if (!serial_in) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == FULL_LAST) begin
          cnt_s   = '0;
          shift_s = shift_in(shift_r, serial_in);
          if (bit_cnt_r == BIT_LAST) begin
            state_s = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_r == FULL_LAST) begin
          cnt_s     = '0;
          par_bad_s = (serial_in != expected_parity(shift_r));
          state_s   = STOP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == FULL_LAST) begin
          cnt_s = '0;
          if (serial_in) begin
            state_s = IDLE;
            if (par_bad_r) begin
              perr_s = 1'b1;
            end else begin
              valid_s = 1'b1;
              data_s  = shift_r;
            end
          end else begin
            // A broken stop bit outranks any parity result.
            ferr_s  = 1'b1;
            state_s = WAIT_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (serial_in) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      par_bad_r  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      par_bad_r  <= par_bad_s;
      data_out   <= data_s;
      data_valid <= valid_s;
      parity_err <= perr_s;
      frame_err  <= ferr_s;
      busy       <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with default parameters (C = 4, even parity).
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int multi_cnt = 0;
  int valid_cyc_prev = 0;
  int valid_cyc_last = 0;
  int base;

  serial_frame_rx #(
    .DATA_W(8),
    .CLKS_PER_BIT(4),
    .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .serial_in(serial_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt      <= valid_cnt + 1;
      valid_cyc_prev <= valid_cyc_last;
      valid_cyc_last <= cyc;
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((int'(data_valid) + int'(parity_err) + int'(frame_err)) > 1) multi_cnt <= multi_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    serial_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    hold(1'b0, 4);
    for (int i = 0; i < 8; i++) hold(d[i], 4);
    hold(p, 4);
    hold(s, 4);
  endtask

  initial begin
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    hold(1'b1, 2);

    // 1: good frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t1_perr_cnt", 32'(perr_cnt), 32'd0);
    check("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("t1_busy", 32'(busy), 32'h0);
    hold(1'b1, 3);

    // 2: parity error on 0x3C
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, 2);
    check("t2_perr_cnt", 32'(perr_cnt), 32'd1);
    check("t2_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t2_data", 32'(data_out), 32'hA5);

    // 3: frame error then line held low
    send_frame(8'h12, 1'b0, 1'b0);
    hold(1'b0, 12);
    check("t3_busy_low_line", 32'(busy), 32'h1);
    check("t3_ferr_cnt", 32'(ferr_cnt), 32'd1);
    hold(1'b1, 4);
    check("t3_busy_released", 32'(busy), 32'h0);
    check("t3_ferr_once", 32'(ferr_cnt), 32'd1);
    check("t3_perr_none", 32'(perr_cnt), 32'd1);
    check("t3_valid_none", 32'(valid_cnt), 32'd1);
    check("t3_data_kept", 32'(data_out), 32'hA5);
    send_frame(8'h55, 1'b0, 1'b1);
    check("t3_data_55", 32'(data_out), 32'h55);
    check("t3_valid_cnt", 32'(valid_cnt), 32'd2);
    hold(1'b1, 3);

    // 4: false start glitch
    hold(1'b0, 1);
    check("t4_busy_a", 32'(busy), 32'h1);
    hold(1'b1, 1);
    check("t4_busy_b", 32'(busy), 32'h1);
    hold(1'b1, 1);
    check("t4_busy_c", 32'(busy), 32'h0);
    hold(1'b1, 4);
    check("t4_valid_cnt", 32'(valid_cnt), 32'd2);
    check("t4_perr_cnt", 32'(perr_cnt), 32'd1);
    check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("t4_data", 32'(data_out), 32'h55);

    // 5: back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b0, 1'b1);
    check("t5_data_00", 32'(data_out), 32'h00);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("t5_data_ff", 32'(data_out), 32'hFF);
    check("t5_valid_cnt", 32'(valid_cnt), 32'd4);
    check("t5_spacing", 32'(valid_cyc_last - valid_cyc_prev), 32'd44);
    hold(1'b1, 3);

    // 6: reset during data bit 3 of 0x81
    hold(1'b0, 4);
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b0, 4);
    serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_busy_pre", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_data", 32'(data_out), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_valid", 32'(data_valid), 32'h0);
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = valid_cnt;
    hold(1'b1, 2);
    send_frame(8'h7E, 1'b0, 1'b1);
    hold(1'b1, 2);
    check("t6_data_7e", 32'(data_out), 32'h7E);
    check("t6_single_valid", 32'(valid_cnt - base), 32'd1);
    check("t6_valid_total", 32'(valid_cnt), 32'd5);
    check("flags_exclusive", 32'(multi_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial frame receiver that consumes the registered bit stream produced by the D flip-flop stage (its Q drives serial_in).
- Detects a start bit, samples each bit at mid-period, and shifts DATA_W data bits in LSB first.
- Optionally checks one parity bit and validates the stop bit.
- Presents the received word with a one-cycle valid pulse, or a one-cycle error pulse, to downstream logic.

Parameters:
DATA_W, 8, number of data bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles per serial bit; must be even and >= 2
PARITY_EN, 1, 1 = a parity bit follows the data bits, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
serial_in  input  1  registered serial line; idle level 1
data_out  output  DATA_W  last correctly received word
data_valid  output  1  one-cycle pulse: data_out updated with a good frame
parity_err  output  1  one-cycle pulse: parity mismatch, frame discarded
frame_err  output  1  one-cycle pulse: stop bit sampled 0, frame discarded
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, active high): state = IDLE; counters, shift register, data_out, data_valid, parity_err, frame_err and busy all 0. Asserting reset mid-frame aborts the frame with no pulse.
- Timing: let C = CLKS_PER_BIT, H = C/2, P = PARITY_EN. Let E0 be the clock edge at which IDLE samples serial_in = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: serial_in = 0 -> START and clear the bit counter. Otherwise remain in IDLE.
- START: sample serial_in at E0+H.
  - Sample 0 -> DATA.
  - Sample 1 -> IDLE as a false start: no pulse, data_out unchanged.
- DATA: data bit k (k = 0..DATA_W-1) is sampled at E0+H+(k+1)*C and shifted in LSB first.
  - After bit DATA_W-1 -> PARITY if P = 1, else STOP.
- PARITY: sample at E0+H+(DATA_W+1)*C.
  - Expected bit = XOR of the data bits, inverted when PARITY_ODD = 1.
  - Latch the mismatch flag, then -> STOP.
- STOP: sample at Es = E0+H+(DATA_W+1+P)*C. Outputs are registered, so a pulse is high for exactly the one cycle following Es.
  - Stop = 1, parity OK: data_out <= shift register and data_valid pulses.
  - Stop = 1, parity bad: parity_err pulses; data_out unchanged.
  - Either case -> IDLE at Es, so a new start bit can be detected from the next edge (back-to-back frames supported).
  - Stop = 0: frame_err pulses (takes priority; parity_err not asserted); data_out unchanged; -> WAIT_IDLE.
- WAIT_IDLE: remain until serial_in = 1, then -> IDLE. Prevents a held-low line being decoded as a new frame.
- busy is registered and equals (state != IDLE). Flags are never asserted simultaneously, and never outside the cycle after Es.
- serial_in changing between sample points is ignored; only mid-bit samples matter.

Test Plan:
(Default parameters: C = 4, even parity.)
1. Good frame: reset 3 cycles, line idle 1. Send 0xA5 as start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit held 4 clks -> data_valid high for exactly 1 cycle, data_out = 0xA5, no error pulses, busy low afterwards.
2. Parity error: send 0x3C with parity bit 1 -> parity_err one-cycle pulse, data_valid stays 0, data_out still 0xA5.
3. Frame error and line hold: send 0x12 with stop bit 0, then hold the line low 12 clks before returning to 1 -> one frame_err pulse, busy high until the line returns to 1, no further pulses. A following good 0x55 frame -> data_out = 0x55.
4. False start: 1-clk low glitch on an idle line -> busy high for H cycles then low, no pulses, data_out unchanged.
5. Back-to-back: frames 0x00 then 0xFF with no idle gap (parity 0 for both) -> two data_valid pulses exactly 44 clks apart, data_out = 0x00 then 0xFF.
6. Reset mid-frame: assert reset during data bit 3 of 0x81 -> all outputs 0 immediately (asynchronously). A full 0x7E frame after release -> data_out = 0x7E with a single data_valid pulse.
